// File: rtl/ldb_axi_req_arb.sv
// Round-robin arbiter sharing one AXI read master among NUM_REQ requesters.
// One transfer in flight; a WAIT timeout aborts the transfer with an error pulse.
module ldb_axi_req_arb #(
    parameter int NUM_REQ        = 2,
    parameter int AXI_ADDR_W     = 64,
    parameter int AXI_DATA_W     = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*AXI_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*9-1:0]          req_len,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [NUM_REQ-1:0]            data_valid,
    output logic [AXI_DATA_W-1:0]         data_out,
    output logic                          data_last,
    output logic                          m_req_valid,
    input  logic                          m_req_ready,
    output logic [AXI_ADDR_W-1:0]         m_req_addr,
    output logic [8:0]                    m_req_len,
    input  logic                          m_req_done,
    input  logic                          m_req_err,
    input  logic                          m_out_valid,
    input  logic [AXI_DATA_W-1:0]         m_out_data,
    input  logic                          m_out_last,
    output logic                          busy,
    output logic [1:0]                    grant_id,
    output logic                          tout_err,
    output logic                          stray_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_last, w_last_nxt;
    logic [1:0]          r_grant, w_grant_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_tout_pulse, w_tout_pulse_nxt;
    logic                r_tout_err, r_stray_err;

    logic                w_sel_found;
    logic [1:0]          w_sel;
    logic                w_sel_len0;
    logic [AXI_ADDR_W-1:0] w_gnt_addr;
    logic [8:0]          w_gnt_len;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel       = '0;
        w_sel_len0  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_sel_found && req_valid[j] &&
                    (j == (int'(r_last) + i) % NUM_REQ)) begin
                    w_sel_found = 1'b1;
                    w_sel       = 2'(j);
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_sel == 2'(j)) begin
                w_sel_len0 = (req_len[j*9 +: 9] == 9'd0);
            end
        end
    end

    always_comb begin
        w_gnt_addr = '0;
        w_gnt_len  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_grant == 2'(j)) begin
                w_gnt_addr = req_addr[j*AXI_ADDR_W +: AXI_ADDR_W];
                w_gnt_len  = req_len[j*9 +: 9];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_nxt       = r_last;
        w_grant_nxt      = r_grant;
        w_cnt_nxt        = r_cnt;
        w_tout_pulse_nxt = 1'b0;
        m_req_valid      = 1'b0;
        m_req_addr       = '0;
        m_req_len        = '0;
        req_ready        = '0;
        req_done         = '0;
        req_err          = '0;
        data_valid       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_grant_nxt = w_sel;
                    if (w_sel_len0) begin
                        w_last_nxt = w_sel;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                m_req_valid = 1'b1;
                m_req_addr  = w_gnt_addr;
                m_req_len   = w_gnt_len;
                if (m_req_ready) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (m_req_done || m_req_err) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_grant;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt      = S_IDLE;
                    w_last_nxt       = r_grant;
                    w_tout_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_grant == 2'(j)) begin
                req_ready[j]  = (r_state == S_ISSUE) && m_req_ready;
                data_valid[j] = (r_state == S_WAIT) && m_out_valid;
                req_done[j]   = (r_state == S_WAIT) && m_req_done;
                req_err[j]    = ((r_state == S_WAIT) && m_req_err) || r_tout_pulse;
            end
            // Zero-length requests are rejected in IDLE without reaching the master.
            if ((r_state == S_IDLE) && w_sel_found && w_sel_len0 && (w_sel == 2'(j))) begin
                req_err[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last       <= 2'(NUM_REQ - 1);
            r_grant      <= '0;
            r_cnt        <= '0;
            r_tout_pulse <= 1'b0;
            r_tout_err   <= 1'b0;
            r_stray_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_grant      <= w_grant_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tout_pulse <= w_tout_pulse_nxt;
            if (w_tout_pulse_nxt) begin
                r_tout_err <= 1'b1;
            end
            if (m_out_valid && (r_state != S_WAIT)) begin
                r_stray_err <= 1'b1;
            end
        end
    end

    assign data_out  = m_out_data;
    assign data_last = m_out_last;
    assign busy      = (r_state != S_IDLE);
    assign grant_id  = r_grant;
    assign tout_err  = r_tout_err;
    assign stray_err = r_stray_err;

endmodule

// File: tb/tb_ldb_axi_req_arb.sv
// Scenario bench for ldb_axi_req_arb; data beats are checked against a queue
// of expected beats filled by the master model.
module tb_ldb_axi_req_arb;

    localparam int NR = 2;
    localparam int AW = 64;
    localparam int DW = 128;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*9-1:0]   req_len;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic [NR-1:0]     data_valid;
    logic [DW-1:0]     data_out;
    logic              data_last;
    logic              m_req_valid;
    logic              m_req_ready;
    logic [AW-1:0]     m_req_addr;
    logic [8:0]        m_req_len;
    logic              m_req_done;
    logic              m_req_err;
    logic              m_out_valid;
    logic [DW-1:0]     m_out_data;
    logic              m_out_last;
    logic              busy;
    logic [1:0]        grant_id;
    logic              tout_err;
    logic              stray_err;

    ldb_axi_req_arb #(
        .NUM_REQ(NR), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .req_done(req_done), .req_err(req_err),
        .data_valid(data_valid), .data_out(data_out), .data_last(data_last),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr), .m_req_len(m_req_len),
        .m_req_done(m_req_done), .m_req_err(m_req_err),
        .m_out_valid(m_out_valid), .m_out_data(m_out_data), .m_out_last(m_out_last),
        .busy(busy), .grant_id(grant_id), .tout_err(tout_err), .stray_err(stray_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        logic        last;
    } beat_t;

    beat_t       sb_q[$];
    beat_t       mon_e;
    int          checks = 0;
    int          failures = 0;
    int          beats_seen = 0;
    logic [NR-1:0] done_acc = '0;

    // Scoreboard monitor: every delivered beat must match the oldest expected one.
    always @(negedge clk) begin
        done_acc = done_acc | req_done;
        if (data_valid !== '0) begin
            beats_seen++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_beat unexpected data_valid=%b, none expected", data_valid);
            end else begin
                mon_e = sb_q.pop_front();
                if (data_valid !== (NR'(1) << mon_e.id) || data_out !== mon_e.data ||
                    data_last !== mon_e.last) begin
                    failures++;
                    $display("FAIL sb_beat got dv=%b data=%h last=%b, want dv=%b data=%h last=%b",
                             data_valid, data_out, data_last, NR'(1) << mon_e.id,
                             mon_e.data, mon_e.last);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_len     = '0;
        m_req_ready = 1'b0;
        m_req_done  = 1'b0;
        m_req_err   = 1'b0;
        m_out_valid = 1'b0;
        m_out_data  = '0;
        m_out_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        done_acc = '0;
    endtask

    // Master model: waits for a request, accepts it, streams nbeats and finishes.
    // fin: 0 = done, 1 = err, 2 = leave the transfer open in WAIT.
    task automatic xfer(input int nbeats, input int fin, output bit ok, output int gnt,
                        output int lat, output logic [NR-1:0] rdy, output logic [AW-1:0] a,
                        output logic [8:0] l, output logic [NR-1:0] dn,
                        output logic [NR-1:0] er);
        bit found = 0;
        ok = 0; gnt = -1; lat = 0; rdy = '0; a = '0; l = '0; dn = '0; er = '0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (m_req_valid === 1'b1) found = 1;
            else lat++;
        end
        if (!found) return;
        gnt = int'(grant_id);
        a   = m_req_addr;
        l   = m_req_len;
        m_req_ready = 1'b1;
        #1;
        rdy = req_ready;
        @(posedge clk);
        #1;
        m_req_ready = 1'b0;
        if (fin == 2) begin
            ok = 1;
            return;
        end
        for (int b = 0; b < nbeats; b++) begin
            m_out_valid = 1'b1;
            m_out_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_out_last  = (b == nbeats - 1);
            sb_q.push_back('{gnt, m_out_data, m_out_last});
            @(posedge clk);
            #1;
        end
        m_out_valid = 1'b0;
        m_out_last  = 1'b0;
        if (fin == 1) m_req_err = 1'b1;
        else          m_req_done = 1'b1;
        @(negedge clk);
        dn = req_done;
        er = req_err;
        @(posedge clk);
        #1;
        m_req_done = 1'b0;
        m_req_err  = 1'b0;
        ok = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_addr = '0; req_len = '0;
        m_req_ready = 0; m_req_done = 0; m_req_err = 0;
        m_out_valid = 0; m_out_data = '0; m_out_last = 0;
        @(negedge clk);
        checks++;
        if ({req_ready, req_done, req_err, data_valid, m_req_valid, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %b, want all zero",
                     {req_ready, req_done, req_err, data_valid, m_req_valid, busy});
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (m_req_addr !== '0 || m_req_len !== '0 || grant_id !== 2'd0 ||
            tout_err !== 1'b0 || stray_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got addr=%h len=%0d gid=%0d tout=%b stray=%b busy=%b, want all 0",
                     m_req_addr, m_req_len, grant_id, tout_err, stray_err, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bit ok; int gnt, lat, b0;
        logic [NR-1:0] rdy, dn, er;
        logic [AW-1:0] a; logic [8:0] l;
        do_reset();
        req_addr[0 +: AW] = 64'h100;
        req_len[0 +: 9]   = 9'd4;
        req_valid = 2'b01;
        b0 = beats_seen;
        xfer(4, 0, ok, gnt, lat, rdy, a, l, dn, er);
        req_valid = '0;
        checks++;
        if (!ok || gnt !== 0 || lat !== 1 || a !== 64'h100 || l !== 9'd4 || rdy !== 2'b01) begin
            failures++;
            $display("FAIL single_issue got ok=%0d gnt=%0d lat=%0d addr=%h len=%0d rdy=%b, want 1 0 1 100 4 01",
                     ok, gnt, lat, a, l, rdy);
        end
        checks++;
        if (beats_seen - b0 !== 4) begin
            failures++;
            $display("FAIL single_beats got %0d, want 4", beats_seen - b0);
        end
        checks++;
        if (dn !== 2'b01 || er !== 2'b00 || done_acc !== 2'b01) begin
            failures++;
            $display("FAIL single_done got dn=%b er=%b acc=%b, want 01 00 01", dn, er, done_acc);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle busy=%b, want 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        bit ok; int gnt, lat;
        logic [NR-1:0] rdy, dn, er;
        logic [AW-1:0] a; logic [8:0] l;
        int exp_g[3] = '{0, 1, 0};
        logic [AW-1:0] exp_a;
        do_reset();
        req_addr = {64'hB000, 64'hA000};
        req_len  = {9'd3, 9'd2};
        req_valid = 2'b11;
        for (int t = 0; t < 3; t++) begin
            xfer((t == 1) ? 3 : 2, (t == 2) ? 1 : 0, ok, gnt, lat, rdy, a, l, dn, er);
            exp_a = (exp_g[t] == 0) ? 64'hA000 : 64'hB000;
            checks++;
            if (!ok || gnt !== exp_g[t] || a !== exp_a || lat !== 1 ||
                rdy !== (NR'(1) << exp_g[t])) begin
                failures++;
                $display("FAIL rr_grant%0d got ok=%0d gnt=%0d addr=%h lat=%0d rdy=%b, want gnt=%0d addr=%h lat=1",
                         t, ok, gnt, a, lat, rdy, exp_g[t], exp_a);
            end
            checks++;
            if (t == 2 ? (er !== 2'b01 || dn !== 2'b00) :
                         (dn !== (NR'(1) << exp_g[t]) || er !== 2'b00)) begin
                failures++;
                $display("FAIL rr_finish%0d got dn=%b er=%b", t, dn, er);
            end
        end
        req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_len();
        bit ok; int gnt, lat;
        logic [NR-1:0] rdy, dn, er;
        logic [AW-1:0] a; logic [8:0] l;
        do_reset();
        req_addr = {64'h2200, 64'h1100};
        req_len  = {9'd1, 9'd0};
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_err !== 2'b01 || m_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL zlen_err got err=%b mvalid=%b, want 01 0", req_err, m_req_valid);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_err !== 2'b00 || m_req_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zlen_after got err=%b mvalid=%b busy=%b, want 00 0 0",
                     req_err, m_req_valid, busy);
        end
        @(posedge clk);
        #1;
        req_len   = {9'd1, 9'd1};
        req_valid = 2'b11;
        xfer(1, 0, ok, gnt, lat, rdy, a, l, dn, er);
        req_valid = '0;
        checks++;
        if (!ok || gnt !== 1 || a !== 64'h2200 || dn !== 2'b10) begin
            failures++;
            $display("FAIL zlen_next got ok=%0d gnt=%0d addr=%h dn=%b, want 1 1 2200 10",
                     ok, gnt, a, dn);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        bit ok, seen; int gnt, lat, cnt;
        logic [NR-1:0] rdy, dn, er;
        logic [AW-1:0] a; logic [8:0] l;
        do_reset();
        req_addr[0 +: AW] = 64'h300;
        req_len[0 +: 9]   = 9'd8;
        req_valid = 2'b01;
        xfer(0, 2, ok, gnt, lat, rdy, a, l, dn, er);
        req_valid = '0;
        cnt = 0; seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (req_err !== 2'b00) seen = 1;
            else cnt++;
        end
        checks++;
        if (!ok || !seen || cnt !== TO || req_err !== 2'b01) begin
            failures++;
            $display("FAIL tout_pulse got ok=%0d seen=%0d wait=%0d err=%b, want 1 1 %0d 01",
                     ok, seen, cnt, req_err, TO);
        end
        checks++;
        if (tout_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL tout_flags got tout=%b busy=%b, want 1 0", tout_err, busy);
        end
        @(negedge clk);
        checks++;
        if (req_err !== 2'b00 || tout_err !== 1'b1) begin
            failures++;
            $display("FAIL tout_after got err=%b tout=%b, want 00 1", req_err, tout_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stray();
        do_reset();
        m_out_valid = 1'b1;
        m_out_data  = {4{32'hDEAD_BEEF}};
        m_req_done  = 1'b1;
        m_req_err   = 1'b1;
        @(negedge clk);
        checks++;
        if (data_valid !== 2'b00 || req_done !== 2'b00 || req_err !== 2'b00) begin
            failures++;
            $display("FAIL stray_drop got dv=%b done=%b err=%b, want 00 00 00",
                     data_valid, req_done, req_err);
        end
        @(posedge clk);
        #1;
        m_out_valid = 1'b0;
        m_req_done  = 1'b0;
        m_req_err   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (stray_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stray_sticky got stray=%b busy=%b, want 1 0", stray_err, busy);
        end
        @(posedge clk);
        #1;
    endtask

    // Continues from a state with stray_err set; the mid-WAIT reset must clear it.
    task automatic test_reset_mid_wait();
        bit ok; int gnt, lat;
        logic [NR-1:0] rdy, dn, er;
        logic [AW-1:0] a; logic [8:0] l;
        req_addr = {64'h4400, 64'h3300};
        req_len  = {9'd2, 9'd2};
        req_valid = 2'b10;
        done_acc  = '0;
        xfer(0, 2, ok, gnt, lat, rdy, a, l, dn, er);
        req_valid = '0;
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_setup got ok=%0d busy=%b, want 1 1", ok, busy);
        end
        rst_n = 1'b0;
        m_out_valid = 1'b1;
        m_req_done  = 1'b1;
        m_req_err   = 1'b1;
        #1;
        checks++;
        if ({req_ready, req_done, req_err, data_valid, m_req_valid, busy} !== '0 ||
            tout_err !== 1'b0 || stray_err !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got %b tout=%b stray=%b gid=%0d, want all 0",
                     {req_ready, req_done, req_err, data_valid, m_req_valid, busy},
                     tout_err, stray_err, grant_id);
        end
        @(negedge clk);
        m_out_valid = 1'b0;
        m_req_done  = 1'b0;
        m_req_err   = 1'b0;
        checks++;
        if (done_acc !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_nodone got acc=%b, want 00", done_acc);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        xfer(2, 0, ok, gnt, lat, rdy, a, l, dn, er);
        req_valid = '0;
        checks++;
        if (!ok || gnt !== 1 || a !== 64'h4400 || lat !== 1 || dn !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_regrant got ok=%0d gnt=%0d addr=%h lat=%0d dn=%b, want 1 1 4400 1 10",
                     ok, gnt, a, lat, dn);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_timeout();
        test_stray();
        test_reset_mid_wait();
        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d beats pending, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ldb_axi_req_arb.md
LDB_AXI_REQ_ARB -- requirements
Module: ldb_axi_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one AXI read master (legal 2..4).
REQ-002 SHALL have parameter AXI_ADDR_W, default 64, request address width.
REQ-003 SHALL have parameter AXI_DATA_W, default 128, read data stream width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum WAIT cycles before forced abort.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted.
- req_addr  in  NUM_REQ*AXI_ADDR_W  packed start addresses; requester i at slice i.
- req_len  in  NUM_REQ*9  packed beat counts; requester i at slice i.
- req_done  out  NUM_REQ  per-requester completion pulse.
- req_err  out  NUM_REQ  per-requester error pulse.
- data_valid  out  NUM_REQ  per-requester data beat strobe.
- data_out  out  AXI_DATA_W  broadcast read data.
- data_last  out  1  broadcast last-beat flag.
- m_req_valid  out  1  request to AXI master.
- m_req_ready  in  1  AXI master accepts request.
- m_req_addr  out  AXI_ADDR_W  granted address.
- m_req_len  out  9  granted length.
- m_req_done  in  1  AXI master transfer complete.
- m_req_err  in  1  AXI master transfer error.
- m_out_valid  in  1  AXI master data beat valid.
- m_out_data  in  AXI_DATA_W  AXI master data.
- m_out_last  in  1  AXI master last beat.
- busy  out  1  arbiter not in IDLE.
- grant_id  out  2  index of current/last granted requester.
- tout_err  out  1  sticky timeout flag.
- stray_err  out  1  sticky flag: data beat outside WAIT.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT; one transfer in flight at a time.
REQ-007 IDLE: when any req_valid is high, SHALL select requester round-robin starting from (last_grant+1) mod NUM_REQ, register grant_id, go to ISSUE next cycle.
REQ-008 IDLE: if the selected requester has req_len==0, SHALL pulse req_err[g] for one cycle, update last_grant, stay IDLE, issue nothing to master.
REQ-009 ISSUE: m_req_valid=1; m_req_addr/m_req_len SHALL mux combinationally from slice grant_id; requester SHALL hold req_valid/addr/len stable until req_ready.
REQ-010 ISSUE: req_ready[grant_id] = m_req_ready (combinational); all other req_ready bits 0; on m_req_valid&&m_req_ready go to WAIT.
REQ-011 WAIT: data_valid[grant_id] = m_out_valid; other bits 0; data_out=m_out_data, data_last=m_out_last at all times.
REQ-012 WAIT: req_done[grant_id] = m_req_done, req_err[grant_id] = m_req_err (combinational, same cycle); on either go to IDLE, last_grant<=grant_id.
REQ-013 m_req_done and m_req_err together SHALL both propagate; the transition is the same.
REQ-014 WAIT counter SHALL clear on entry, increment each WAIT cycle; on reaching TIMEOUT_CYCLES without done/err: pulse req_err[grant_id] (registered, 1 cycle), set tout_err, go to IDLE.
REQ-015 m_out_valid outside WAIT SHALL be dropped (no data_valid) and set stray_err.
REQ-016 m_req_done/m_req_err outside WAIT SHALL be ignored.
REQ-017 Minimum spacing: grant in IDLE at cycle n, ISSUE at n+1; after done, IDLE at next cycle, next ISSUE one cycle later.
REQ-018 busy = (state != IDLE).

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, last_grant=NUM_REQ-1, grant_id=0, counter=0, tout_err=0, stray_err=0.
REQ-020 During/after reset all outputs SHALL be 0: req_ready, req_done, req_err, data_valid, m_req_valid, busy; m_req_addr/m_req_len 0 in IDLE.
REQ-021 Reset asserted in ISSUE/WAIT SHALL abandon the transfer without any req_done/req_err pulse.

Verification
REQ-022 req_valid=2'b01, addr=0x100, len=4 -> m_req_valid next cycle with addr 0x100 len 4; 4 beats on data_valid[0]; req_done[0] with m_req_done; req_done[1] never.
REQ-023 req_valid=2'b11 held for 3 transfers after reset -> grant order 0,1,0.
REQ-024 req_len[0]=0, valid -> req_err[0] one cycle, m_req_valid stays 0, next grant starts at requester 1.
REQ-025 master never asserts done, TIMEOUT_CYCLES=16 -> req_err[g] after 16 WAIT cycles, tout_err=1, busy=0 next cycle.
REQ-026 m_out_valid pulse in IDLE -> no data_valid, stray_err=1 until reset.
REQ-027 rst_n low mid-WAIT -> all outputs 0 immediately, flags 0, no done/err pulse; next request granted normally.
